audio_framer: RTL and testbench
===============================

// Module: audio_framer
// PURPOSE
//  Front-end stage ahead of the windowing stage in the MFCC/keyword-spotting chain.
//  Accepts a stream of signed PCM samples and applies optional first-order pre-emphasis.
//  Assembles overlapping frames of FRAME_SIZE samples, advancing HOP_SIZE samples per frame.
//  Presents each complete frame in parallel with a one-cycle frame_valid pulse for windowing.
// PARAMETERS
//  DATA_WIDTH  16     sample width, two's complement
//  FRAME_SIZE  256    samples per frame (>=2)
//  HOP_SIZE    128    samples between frame starts (1..FRAME_SIZE)
//  PREEMPH_EN  1      1: y[n]=x[n]-ALPHA*x[n-1]; 0: y[n]=x[n]
//  ALPHA_Q15   31785  pre-emphasis coefficient, unsigned Q1.15 (~0.97)
// PORTS
//  clk           in   1                     clock
//  rst_n         in   1                     reset, asynchronous, active-low
//  enable        in   1                     0: synchronous flush to FILL state
//  sample_in     in   DATA_WIDTH            signed input sample
//  sample_valid  in   1                     sample_in accepted this cycle (any duty, incl. every cycle)
//  frame_data    out  FRAME_SIZE*DATA_WIDTH packed frame; slot i at [i*DATA_WIDTH +: DATA_WIDTH], i=0 oldest
//  frame_valid   out  1                     one-cycle pulse: frame_data updated this cycle
//  frame_count   out  16                    frames emitted since reset, wraps 0xFFFF->0
//  filling       out  1                     1 while in FILL state
// BEHAVIOUR
//  Reset values:
//   - frame_data=0, frame_valid=0, frame_count=0, filling=1.
//   - Sample buffer=0, x_prev=0, fill_cnt=0, hop_cnt=0, state=FILL.
//  Sample accept: sample_valid=1 and enable=1.
//  Pre-emphasis (PREEMPH_EN=1):
//   - y = sat(x - ((ALPHA_Q15*x_prev)>>>15)); product signed, full width.
//   - Shift is arithmetic, truncating toward -inf; sat clamps to [-2^(DW-1), 2^(DW-1)-1].
//   - x_prev <= x on each accept.
//  Buffer: FRAME_SIZE-deep history of y; each accept shifts in y as newest and drops the oldest.
//  FSM state FILL:
//   - fill_cnt increments per accept.
//   - On the FRAME_SIZE-th accept: emit frame, go RUN, hop_cnt=0.
//  FSM state RUN:
//   - hop_cnt increments per accept.
//   - On the HOP_SIZE-th accept since the last emit: emit, hop_cnt=0.
//  Emit:
//   - Next edge loads frame_data with the buffer including the just-accepted sample.
//   - Same edge: frame_valid=1, frame_count+1.
//   - Latency: frame_valid high exactly 1 cycle after the completing sample's accept edge, for 1 cycle.
//  frame_data holds its value between emits; there is no downstream backpressure.
//   - Downstream must consume within HOP_SIZE accepts.
//  HOP_SIZE==FRAME_SIZE: non-overlapping frames. HOP_SIZE==1: a frame on every accept once RUN.
//  enable=0 (synchronous, any state incl. mid-fill):
//   - state=FILL; fill_cnt, hop_cnt, x_prev and buffer cleared to 0; no emit that cycle.
//   - frame_data and frame_count hold. Samples presented while enable=0 are ignored.
//  enable and sample_valid are sampled on the same edge; enable=0 takes priority.
//  Async reset mid-frame: all state returns to reset values immediately; the next frame needs a full refill.
// TESTING (FRAME_SIZE=8, HOP_SIZE=4, DATA_WIDTH=16 unless noted)
//  1. PREEMPH_EN=0, feed 1..8 back-to-back:
//     -> one frame_valid pulse the cycle after sample 8; frame_data slots 0..7 = 1..8; frame_count=1; filling=0.
//  2. Continue with 9..16, sample_valid every other cycle:
//     -> frames {5..12} and {9..16}; each pulse 1 cycle after samples 12 and 16; frame_data stable between pulses.
//  3. PREEMPH_EN=1, ALPHA_Q15=16384, inputs 100,100,...:
//     -> first y=100, then y=50; input -32768 after prev 32767 -> y saturates to -32768.
//  4. enable=0 for one cycle after 6 samples of a fill, then feed 8 more:
//     -> no pulse until the 8th new sample; frame = the new 8 only; frame_count unchanged by the flush.
//  5. rst_n asserted mid-RUN, then released:
//     -> all outputs = reset values; the next frame needs 8 fresh samples.
//  6. HOP_SIZE=1 and HOP_SIZE=8 variants with continuous input:
//     -> pulses every accept after fill, resp. every 8th accept; frame_count wrap checked by forcing 0xFFFF -> 0.

Source files
------------

// File: rtl/audio_framer.sv
// audio_framer: optional first-order pre-emphasis followed by an overlapping
// frame assembler. Emits FRAME_SIZE samples in parallel every HOP_SIZE accepts
// once the first frame has filled.
module audio_framer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FRAME_SIZE = 256,
    parameter int unsigned HOP_SIZE   = 128,
    parameter int unsigned PREEMPH_EN = 1,
    parameter int unsigned ALPHA_Q15  = 31785
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [DATA_WIDTH-1:0]            sample_in,
    input  logic                             sample_valid,
    output logic [FRAME_SIZE*DATA_WIDTH-1:0] frame_data,
    output logic                             frame_valid,
    output logic [15:0]                      frame_count,
    output logic                             filling
);

    localparam int unsigned BUF_W  = FRAME_SIZE * DATA_WIDTH;
    localparam int unsigned FILL_W = $clog2(FRAME_SIZE + 1);
    localparam int unsigned HOP_W  = $clog2(HOP_SIZE + 1);
    localparam int unsigned COEF_W = 17;
    localparam int unsigned PROD_W = DATA_WIDTH + COEF_W;
    localparam int unsigned DIFF_W = DATA_WIDTH + 2;

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FRAME_SIZE - 1);
    localparam logic [HOP_W-1:0]  HOP_LAST  = HOP_W'(HOP_SIZE - 1);

    // Coefficient kept positive by carrying one extra sign bit above Q1.15.
    localparam logic signed [COEF_W-1:0] ALPHA_S = COEF_W'(ALPHA_Q15);
    localparam logic signed [DIFF_W-1:0] SAT_MAX = DIFF_W'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [DIFF_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [BUF_W-1:0]             buf_q;
    logic [BUF_W-1:0]             buf_shift_c;
    logic signed [DATA_WIDTH-1:0] x_prev_q;
    logic signed [DATA_WIDTH-1:0] x_in_s;
    logic [FILL_W-1:0]            fill_q;
    logic [FILL_W-1:0]            fill_d;
    logic [HOP_W-1:0]             hop_q;
    logic [HOP_W-1:0]             hop_d;
    logic                         accept_c;
    logic                         emit_c;
    logic [15:0]                  count_next_c;

    logic signed [PROD_W-1:0]     prod_c;
    logic signed [PROD_W-1:0]     scaled_c;
    logic signed [DIFF_W-1:0]     diff_c;
    logic signed [DIFF_W-1:0]     sat_c;
    logic signed [DATA_WIDTH-1:0] y_c;

    assign x_in_s       = sample_in;
    assign accept_c     = enable & sample_valid;
    assign count_next_c = frame_count + 16'd1;

    // Pre-emphasis: y = sat(x - floor(alpha * x_prev / 2^15)), or bypass.
    always_comb begin
        prod_c   = PROD_W'(ALPHA_S) * PROD_W'(x_prev_q);
        scaled_c = prod_c >>> 15;
        diff_c   = DIFF_W'(x_in_s) - DIFF_W'(scaled_c);
        if (diff_c > SAT_MAX) begin
            sat_c = SAT_MAX;
        end else if (diff_c < SAT_MIN) begin
            sat_c = SAT_MIN;
        end else begin
            sat_c = diff_c;
        end
        if (PREEMPH_EN != 0) begin
            y_c = DATA_WIDTH'(sat_c);
        end else begin
            y_c = x_in_s;
        end
    end

    // History with the new sample entering at the newest (top) slot.
    always_comb begin
        buf_shift_c = {y_c, buf_q[BUF_W-1:DATA_WIDTH]};
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush wins, FILL leaves on the accept that completes a frame.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = S_FILL;
        end else if (accept_c && (state_q == S_FILL) && (fill_q == FILL_LAST)) begin
            state_d = S_RUN;
        end
    end

    // FSM outputs: emit decision and fill/hop counter updates.
    always_comb begin
        emit_c = 1'b0;
        fill_d = fill_q;
        hop_d  = hop_q;
        if (!enable) begin
            fill_d = '0;
            hop_d  = '0;
        end else if (accept_c) begin
            case (state_q)
                S_FILL: begin
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_LAST) begin
                        emit_c = 1'b1;
                        hop_d  = '0;
                    end
                end
                S_RUN: begin
                    if (hop_q == HOP_LAST) begin
                        emit_c = 1'b1;
                        hop_d  = '0;
                    end else begin
                        hop_d = hop_q + HOP_W'(1);
                    end
                end
                default: begin
                    emit_c = 1'b0;
                end
            endcase
        end
    end

    // Sample history, previous raw input and counters; enable low clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q    <= '0;
            x_prev_q <= '0;
            fill_q   <= '0;
            hop_q    <= '0;
        end else begin
            fill_q <= fill_d;
            hop_q  <= hop_d;
            if (!enable) begin
                buf_q    <= '0;
                x_prev_q <= '0;
            end else if (accept_c) begin
                buf_q    <= buf_shift_c;
                x_prev_q <= x_in_s;
            end
        end
    end

    // Registered frame outputs; frame_data and frame_count hold between emits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            filling     <= 1'b1;
        end else begin
            frame_valid <= emit_c;
            filling     <= (state_d == S_FILL);
            if (emit_c) begin
                frame_data  <= buf_shift_c;
                frame_count <= count_next_c;
            end
        end
    end

endmodule

// File: tb/tb_audio_framer.sv
// Bench for audio_framer: four instances (plain hop 4, pre-emphasis hop 4,
// hop 1, hop 8) share one stimulus stream; a reference model pushes expected
// frames into a scoreboard queue that is drained as pulses appear.
module tb_audio_framer;

    localparam int unsigned DW = 16;
    localparam int unsigned FS = 8;
    localparam int unsigned BW = FS * DW;
    localparam int unsigned NI = 4;
    localparam int HOP_M [NI] = '{4, 4, 1, 8};
    localparam int PRE_M [NI] = '{0, 1, 0, 0};

    typedef struct packed {
        logic [BW-1:0] frame;
        logic [15:0]   cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic          sample_valid;
    logic [DW-1:0] sample_in;
    logic [BW-1:0] fd [NI];
    logic          fv [NI];
    logic [15:0]   fc [NI];
    logic          fl [NI];

    exp_t          exp_q [$];
    int            n_chk;
    int            n_pass;
    int            hist [NI][FS];
    int            fill_m [NI];
    int            hop_m [NI];
    bit            run_m [NI];
    int            xprev_m [NI];
    int            cnt_m [NI];
    logic [BW-1:0] last_m [NI];
    bit            emit_m [NI];
    bit            force3;

    audio_framer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(4), .PREEMPH_EN(0), .ALPHA_Q15(31785)) dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_data(fd[0]), .frame_valid(fv[0]), .frame_count(fc[0]), .filling(fl[0]));
    audio_framer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(4), .PREEMPH_EN(1), .ALPHA_Q15(16384)) dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_data(fd[1]), .frame_valid(fv[1]), .frame_count(fc[1]), .filling(fl[1]));
    audio_framer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(1), .PREEMPH_EN(0), .ALPHA_Q15(31785)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_data(fd[2]), .frame_valid(fv[2]), .frame_count(fc[2]), .filling(fl[2]));
    audio_framer #(.DATA_WIDTH(16), .FRAME_SIZE(8), .HOP_SIZE(8), .PREEMPH_EN(0), .ALPHA_Q15(31785)) dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sample_in(sample_in), .sample_valid(sample_valid),
        .frame_data(fd[3]), .frame_valid(fv[3]), .frame_count(fc[3]), .filling(fl[3]));

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic model_clear(input int k);
        for (int i = 0; i < int'(FS); i++) hist[k][i] = 0;
        fill_m[k]  = 0;
        hop_m[k]   = 0;
        run_m[k]   = 1'b0;
        xprev_m[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < int'(NI); k++) begin
            model_clear(k);
            cnt_m[k]  = 0;
            last_m[k] = '0;
            emit_m[k] = 1'b0;
        end
    endtask

    task automatic model_emit(input int k);
        logic [BW-1:0] f;
        exp_t          e;
        f = '0;
        for (int i = 0; i < int'(FS); i++) f[i*DW +: DW] = 16'(hist[k][i]);
        if (force3 && k == 3) cnt_m[k] = 32'h0000_FFFF;
        else cnt_m[k] = (cnt_m[k] + 1) & 32'h0000_FFFF;
        emit_m[k] = 1'b1;
        last_m[k] = f;
        e.frame   = f;
        e.cnt     = 16'(cnt_m[k]);
        exp_q.push_back(e);
    endtask

    task automatic model_step(input int x, input bit v, input bit en);
        int y;
        for (int k = 0; k < int'(NI); k++) begin
            emit_m[k] = 1'b0;
            if (!en) begin
                model_clear(k);
            end else if (v) begin
                if (PRE_M[k] != 0) begin
                    y = x - ((16384 * xprev_m[k]) >>> 15);
                    if (y > 32767) y = 32767;
                    if (y < -32768) y = -32768;
                end else begin
                    y = x;
                end
                xprev_m[k] = x;
                for (int i = 0; i < int'(FS) - 1; i++) hist[k][i] = hist[k][i+1];
                hist[k][FS-1] = y;
                if (!run_m[k]) begin
                    fill_m[k]++;
                    if (fill_m[k] == int'(FS)) begin
                        run_m[k] = 1'b1;
                        hop_m[k] = 0;
                        model_emit(k);
                    end
                end else begin
                    hop_m[k]++;
                    if (hop_m[k] == HOP_M[k]) begin
                        hop_m[k] = 0;
                        model_emit(k);
                    end
                end
            end
        end
    endtask

    // One clock: drive at negedge, model it, compare at the following negedge.
    task automatic step(input int x, input bit v, input bit en);
        exp_t e;
        sample_in    = 16'(x);
        sample_valid = v;
        enable       = en;
        model_step(x, v, en);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("valid%0d", k), BW'(fv[k]), BW'(emit_m[k]));
            chk($sformatf("filling%0d", k), BW'(fl[k]), BW'(!run_m[k]));
            if (emit_m[k]) begin
                e = exp_q.pop_front();
                chk($sformatf("frame%0d", k), fd[k], e.frame);
                chk($sformatf("count%0d", k), BW'(fc[k]), BW'(e.cnt));
            end else begin
                chk($sformatf("hold_frame%0d", k), fd[k], last_m[k]);
                chk($sformatf("hold_count%0d", k), BW'(fc[k]), BW'(cnt_m[k]));
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < int'(NI); k++) begin
            chk($sformatf("%s_data%0d", tag, k), fd[k], '0);
            chk($sformatf("%s_valid%0d", tag, k), BW'(fv[k]), '0);
            chk($sformatf("%s_count%0d", tag, k), BW'(fc[k]), '0);
            chk($sformatf("%s_filling%0d", tag, k), BW'(fl[k]), BW'(1'b1));
        end
    endtask

    function automatic logic [BW-1:0] ramp(input int first);
        logic [BW-1:0] f;
        f = '0;
        for (int i = 0; i < int'(FS); i++) f[i*DW +: DW] = 16'(first + i);
        return f;
    endfunction

    initial begin
        logic [DW-1:0] slot;
        n_chk        = 0;
        n_pass       = 0;
        force3       = 1'b0;
        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        model_reset();
        @(negedge clk);
        chk_reset("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fill with samples 1..8.
        for (int i = 1; i <= 8; i++) step(i, 1'b1, 1'b1);
        chk("t1_frame", fd[0], ramp(1));
        chk("t1_count", BW'(fc[0]), BW'(16'd1));
        chk("t1_filling", BW'(fl[0]), '0);

        // Samples 9..16 on every other cycle.
        for (int i = 9; i <= 16; i++) begin
            step(i, 1'b1, 1'b1);
            step(0, 1'b0, 1'b1);
        end
        chk("t2_frame", fd[0], ramp(9));
        chk("t2_count", BW'(fc[0]), BW'(16'd3));

        // Pre-emphasis with alpha 0.5 and a saturating step.
        step(0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(100, 1'b1, 1'b1);
        step(32767, 1'b1, 1'b1);
        step(-32768, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        step(0, 1'b1, 1'b1);
        slot = fd[1][0 +: DW];
        chk("t3_first_y", BW'(slot), BW'(16'd100));
        slot = fd[1][DW +: DW];
        chk("t3_second_y", BW'(slot), BW'(16'd50));
        slot = fd[1][4*DW +: DW];
        chk("t3_step_y", BW'(slot), BW'(16'd32717));
        slot = fd[1][5*DW +: DW];
        chk("t3_sat_y", BW'(slot), BW'(16'h8000));
        slot = fd[1][6*DW +: DW];
        chk("t3_neg_prev_y", BW'(slot), BW'(16'd16384));

        // Flush part-way through a fill; the ignored sample must not land.
        step(0, 1'b0, 1'b0);
        for (int i = 11; i <= 16; i++) step(i, 1'b1, 1'b1);
        step(99, 1'b1, 1'b0);
        for (int i = 21; i <= 28; i++) step(i, 1'b1, 1'b1);
        chk("t4_frame", fd[0], ramp(21));
        chk("t4_count", BW'(fc[0]), BW'(16'd5));

        // Asynchronous reset in the middle of RUN.
        step(30, 1'b1, 1'b1);
        step(31, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("async");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 41; i <= 48; i++) step(i, 1'b1, 1'b1);
        chk("t5_frame", fd[0], ramp(41));
        chk("t5_count", BW'(fc[0]), BW'(16'd1));

        // Continuous input for hop 1 and hop 8; counter wrap on the hop-8 instance.
        step(0, 1'b0, 1'b0);
        force3 = 1'b1;
        force dut3.count_next_c = 16'hFFFF;
        for (int i = 61; i <= 68; i++) step(i, 1'b1, 1'b1);
        release dut3.count_next_c;
        force3 = 1'b0;
        chk("t6_count_max", BW'(fc[3]), BW'(16'hFFFF));
        for (int i = 69; i <= 76; i++) step(i, 1'b1, 1'b1);
        chk("t6_count_wrap", BW'(fc[3]), '0);
        chk("t6_hop1_count", BW'(fc[2]), BW'(16'd10));
        chk("t6_hop8_frame", fd[3], ramp(69));
        chk("t6_queue_empty", BW'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
